mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single processor-to-memory port between the icache miss path and the dcache miss/store path.
- Grants at most one command per cycle and passes memory's response back combinationally to the granted requester. The loser sees response 0, which it treats as a reject and retries.
- Keeps a tag-ownership table so each completed transaction's tag is routed only to the requester that issued it.

Parameters:
- STARVE_LIMIT, 8: consecutive icache rejects caused by dcache priority before icache is forced to win.
- NUM_TAGS, 16: memory tag space; tag 0 means "none/rejected".

Ports:
- clock input 1: system clock.
- reset input 1: synchronous, active-high reset.
- icache2arb_command input 2: BUS_NONE or BUS_LOAD from icache.
- icache2arb_addr input 32: icache request address, 8-byte aligned.
- arb2icache_response output 4: memory response forwarded to icache; 0 means rejected.
- arb2icache_tag output 4: completed tag owned by icache; 0 otherwise.
- dcache2arb_command input 2: BUS_NONE, BUS_LOAD or BUS_STORE from dcache.
- dcache2arb_addr input 32: dcache request address.
- dcache2arb_data input 64: store data.
- arb2dcache_response output 4: memory response forwarded to dcache.
- arb2dcache_tag output 4: completed tag owned by dcache; 0 otherwise.
- proc2mem_command output 2: command to memory.
- proc2mem_addr output 32: address to memory.
- proc2mem_data output 64: store data to memory.
- mem2proc_response input 4: memory accept tag, valid the same cycle as the command; 0 means rejected.
- mem2proc_tag input 4: tag of the completing load; 0 means none.
- arb_outstanding output 5: number of loads in flight.
- arb_orphan output 1: one-cycle pulse when a nonzero tag returns that has no valid owner.

Behaviour:
- Grant logic is combinational.
  - req_i = icache command != BUS_NONE.
  - req_d = dcache command != BUS_NONE.
  - Default priority goes to dcache.
  - Icache wins if req_i && (!req_d || starve_cnt >= STARVE_LIMIT).
- Muxing:
  - The granted requester's command and addr drive proc2mem.
  - proc2mem_data = dcache2arb_data when dcache is granted, else 0.
  - With no grant: BUS_NONE, addr 0, data 0.
- Response routing:
  - The granted side gets mem2proc_response.
  - The non-granted side gets 0 in the same cycle.
- starve_cnt is a register, $clog2(STARVE_LIMIT+1) bits, saturating:
  - Increments when req_i && dcache granted.
  - Clears when icache is granted with a nonzero response, or when !req_i.
  - Holds when icache is granted but rejected.
- Ownership table: NUM_TAGS entries of {valid, owner}, owner 0 = icache, 1 = dcache.
  - An accepted BUS_LOAD (response != 0) sets entry[response] = {1, grantee} at the clock edge.
  - BUS_STORE never allocates an entry.
- Tag return, when mem2proc_tag != 0:
  - If entry[tag].valid, the tag goes to the owner's tag output and the other side's tag output is 0; the entry clears at the edge.
  - If the entry is invalid, both tag outputs are 0 and arb_orphan = 1 for that cycle, combinationally.
- Simultaneous return of tag T and accept of tag T in the same cycle:
  - The return is routed using the pre-edge entry.
  - After the edge, the entry holds the new allocation; set wins over clear.
- arb_outstanding:
  - Counts valid entries.
  - Updates +1 / -1 / 0 per cycle for allocate, clear, or both.
  - Never exceeds NUM_TAGS-1.
- Reset, synchronous:
  - All table entries invalid; starve_cnt = 0; arb_outstanding = 0.
  - A tag returning after reset is treated as orphan.
- Combinational outputs during a reset cycle still follow the current inputs.
- Latency: zero-cycle grant and response; tag routing is zero-cycle from mem2proc_tag.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Fixed priority and starve_cnt are replaced by a 1-bit last_grant register.
  - On conflict, the requester that was not last granted with a nonzero response wins.
  - last_grant updates only on an accepted request.
  - Reset value 1, so icache wins the first conflict.
- Undefined: dcache priority plus STARVE_LIMIT starvation guard, as described above.

Test Plan:
- Icache only: BUS_LOAD at 0x1000, response 3 → proc2mem_addr = 0x1000, arb2icache_response = 3, arb2dcache_response = 0, arb_outstanding goes 0→1. Tag 3 returns later → arb2icache_tag = 3, arb2dcache_tag = 0, outstanding back to 0.
- Conflict: both issue BUS_LOAD, response 5 → dcache granted, arb2dcache_response = 5, arb2icache_response = 0. Tag 5 routes only to dcache.
- Starvation, default build: both request continuously for 8 cycles with memory accepting → the 9th cycle grants icache. starve_cnt is 0 after icache is accepted.
- Store: dcache BUS_STORE with data 0xDEADBEEF_CAFEF00D, response 7 → proc2mem_data matches, no table allocation, arb_outstanding unchanged. A later mem2proc_tag = 7 → arb_orphan = 1, both tag outputs 0.
- Same-cycle reuse: icache owns tag 2, tag 2 returns while dcache is accepted with response 2 → arb2icache_tag = 2 that cycle. The next return of tag 2 goes to dcache.
- Reset mid-flight: 3 loads outstanding, assert reset for 1 cycle → arb_outstanding = 0. Returning tags produce arb_orphan pulses and no tag outputs.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory port between icache and dcache and routes returning load tags.
// Define MEM_ARB_RR_EN to replace dcache priority and the starvation guard with round-robin.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned NUM_TAGS     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache2arb_command,
  input  logic [31:0] icache2arb_addr,
  output logic [3:0]  arb2icache_response,
  output logic [3:0]  arb2icache_tag,
  input  logic [1:0]  dcache2arb_command,
  input  logic [31:0] dcache2arb_addr,
  input  logic [63:0] dcache2arb_data,
  output logic [3:0]  arb2dcache_response,
  output logic [3:0]  arb2dcache_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  output logic [4:0]  arb_outstanding,
  output logic        arb_orphan
);

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  logic req_i, req_d, grant_i, grant_d, accepted;

  assign req_i    = icache2arb_command != BUS_NONE;
  assign req_d    = dcache2arb_command != BUS_NONE;
  assign grant_d  = req_d && !grant_i;
  assign accepted = (grant_i || grant_d) && (mem2proc_response != 4'd0);

`ifdef MEM_ARB_RR_EN
  // last_grant: 0 = icache, 1 = dcache; the other side wins the next conflict.
  logic last_grant_q, last_grant_d;

  assign grant_i = req_i && (!req_d || last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (accepted) last_grant_d = grant_d;
  end

  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

  assign grant_i = req_i && (!req_d || starve_cnt_q >= StarveMax);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req_i) begin
      starve_cnt_d = '0;
    end else if (grant_i) begin
      // A rejected icache grant keeps its accumulated priority.
      if (accepted) starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + StarveW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`endif

  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = 32'd0;
    proc2mem_data       = 64'd0;
    arb2icache_response = 4'd0;
    arb2dcache_response = 4'd0;
    if (grant_i) begin
      proc2mem_command    = icache2arb_command;
      proc2mem_addr       = icache2arb_addr;
      arb2icache_response = mem2proc_response;
    end else if (grant_d) begin
      proc2mem_command    = dcache2arb_command;
      proc2mem_addr       = dcache2arb_addr;
      proc2mem_data       = dcache2arb_data;
      arb2dcache_response = mem2proc_response;
    end
  end

  // Tag ownership table; owner 0 = icache, 1 = dcache.
  logic [NUM_TAGS-1:0] valid_q, valid_d, owner_q, owner_d;
  logic tag_ret, tag_hit, alloc;

  assign tag_ret = mem2proc_tag != 4'd0;
  assign tag_hit = tag_ret && valid_q[mem2proc_tag];
  assign alloc   = accepted && (proc2mem_command == BUS_LOAD);

  always_comb begin
    arb2icache_tag = 4'd0;
    arb2dcache_tag = 4'd0;
    arb_orphan     = tag_ret && !tag_hit;
    if (tag_hit) begin
      if (owner_q[mem2proc_tag]) arb2dcache_tag = mem2proc_tag;
      else                       arb2icache_tag = mem2proc_tag;
    end
  end

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (tag_hit) valid_d[mem2proc_tag] = 1'b0;
    // Applied after the clear so a same-cycle reuse of a tag keeps the new owner.
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    arb_outstanding = 5'd0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      arb_outstanding = arb_outstanding + 5'(valid_q[i]);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  localparam logic [1:0] N = 2'h0;
  localparam logic [1:0] L = 2'h1;
  localparam logic [1:0] S = 2'h2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command, dcache2arb_command, proc2mem_command;
  logic [31:0] icache2arb_addr, dcache2arb_addr, proc2mem_addr;
  logic [63:0] dcache2arb_data, proc2mem_data;
  logic [3:0]  arb2icache_response, arb2icache_tag, arb2dcache_response, arb2dcache_tag;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [4:0]  arb_outstanding;
  logic        arb_orphan;

  mem_bus_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .icache2arb_command (icache2arb_command),
    .icache2arb_addr    (icache2arb_addr),
    .arb2icache_response(arb2icache_response),
    .arb2icache_tag     (arb2icache_tag),
    .dcache2arb_command (dcache2arb_command),
    .dcache2arb_addr    (dcache2arb_addr),
    .dcache2arb_data    (dcache2arb_data),
    .arb2dcache_response(arb2dcache_response),
    .arb2dcache_tag     (arb2dcache_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_tag       (mem2proc_tag),
    .arb_outstanding    (arb_outstanding),
    .arb_orphan         (arb_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  ir, dr, it, dt;
    logic [4:0]  outs;
    logic        orph;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vnum   = 0;

  task automatic chk(input string name, input int v, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s: got %0h expected %0h", v, name, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("proc2mem_command", e.idx, 64'(proc2mem_command), 64'(e.cmd));
      chk("proc2mem_addr", e.idx, 64'(proc2mem_addr), 64'(e.addr));
      chk("proc2mem_data", e.idx, proc2mem_data, e.data);
      chk("arb2icache_response", e.idx, 64'(arb2icache_response), 64'(e.ir));
      chk("arb2dcache_response", e.idx, 64'(arb2dcache_response), 64'(e.dr));
      chk("arb2icache_tag", e.idx, 64'(arb2icache_tag), 64'(e.it));
      chk("arb2dcache_tag", e.idx, 64'(arb2dcache_tag), 64'(e.dt));
      chk("arb_outstanding", e.idx, 64'(arb_outstanding), 64'(e.outs));
      chk("arb_orphan", e.idx, 64'(arb_orphan), 64'(e.orph));
    end
  end

  // One cycle: drive inputs just after the edge, queue the expected outputs for that cycle.
  task automatic step(input logic rst, input logic [1:0] ic, input logic [31:0] ia,
                      input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                      input logic [3:0] mr, input logic [3:0] mt,
                      input logic [1:0] ec, input logic [31:0] ea, input logic [63:0] ed,
                      input logic [3:0] eir, input logic [3:0] edr,
                      input logic [3:0] eit, input logic [3:0] edt,
                      input logic [4:0] eo, input logic eorph);
    exp_t e;
    @(posedge clock);
    #1;
    reset              = rst;
    icache2arb_command = ic;
    icache2arb_addr    = ia;
    dcache2arb_command = dc;
    dcache2arb_addr    = da;
    dcache2arb_data    = dd;
    mem2proc_response  = mr;
    mem2proc_tag       = mt;
    vnum++;
    e.idx  = vnum;
    e.cmd  = ec;
    e.addr = ea;
    e.data = ed;
    e.ir   = eir;
    e.dr   = edr;
    e.it   = eit;
    e.dt   = edt;
    e.outs = eo;
    e.orph = eorph;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] mt, input logic [3:0] eit, input logic [3:0] edt,
                      input logic [4:0] eo, input logic eorph);
    step(0, N, 0, N, 0, 0, 0, mt, N, 0, 0, 0, 0, eit, edt, eo, eorph);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    icache2arb_command = N;
    icache2arb_addr    = 0;
    dcache2arb_command = N;
    dcache2arb_addr    = 0;
    dcache2arb_data    = 0;
    mem2proc_response  = 0;
    mem2proc_tag       = 0;
    repeat (2) @(posedge clock);

    // Reset state, then icache-only load and its tag return.
    idle(0, 0, 0, 0, 0);
    step(0, L, 32'h1000, N, 0, 0, 4'd3, 0, L, 32'h1000, 0, 4'd3, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 1, 0);
    idle(4'd3, 4'd3, 0, 1, 0);
    idle(0, 0, 0, 0, 0);

    // Conflict: dcache wins, its data drives the bus, tag 5 goes to dcache only.
    step(0, L, 32'h2000, L, 32'h3000, 64'h1111, 4'd5, 0,
         L, 32'h3000, 64'h1111, 0, 4'd5, 0, 0, 0, 0);
    idle(4'd5, 0, 4'd5, 1, 0);
    idle(0, 0, 0, 0, 0);

    // Starvation: eight dcache wins, then icache forced through, then dcache again.
    for (int k = 1; k <= 8; k++) begin
      step(0, L, 32'h4000, L, 32'h5000, 0, 4'(k), 0,
           L, 32'h5000, 0, 0, 4'(k), 0, 0, 5'(k - 1), 0);
    end
    step(0, L, 32'h4000, L, 32'h5000, 0, 4'd9, 0, L, 32'h4000, 0, 4'd9, 0, 0, 0, 5'd8, 0);
    step(0, L, 32'h4000, L, 32'h5000, 0, 4'd10, 0, L, 32'h5000, 0, 0, 4'd10, 0, 0, 5'd9, 0);

    // Reset with ten in flight; combinational paths still follow inputs in that cycle.
    step(1, L, 32'h6000, N, 0, 0, 4'd11, 0, L, 32'h6000, 0, 4'd11, 0, 0, 0, 5'd10, 0);
    idle(4'd9, 0, 0, 0, 1);
    idle(4'd1, 0, 0, 0, 1);

    // Store: data forwarded, no allocation, its tag returning is an orphan.
    step(0, N, 0, S, 32'h7000, 64'hDEADBEEF_CAFEF00D, 4'd7, 0,
         S, 32'h7000, 64'hDEADBEEF_CAFEF00D, 0, 4'd7, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);
    idle(4'd7, 0, 0, 0, 1);

    // Same-cycle reuse of tag 2: return routed to icache, reallocation owned by dcache.
    step(0, L, 32'h8000, N, 0, 0, 4'd2, 0, L, 32'h8000, 0, 4'd2, 0, 0, 0, 0, 0);
    step(0, N, 0, L, 32'h9000, 0, 4'd2, 4'd2, L, 32'h9000, 0, 0, 4'd2, 4'd2, 0, 5'd1, 0);
    idle(0, 0, 0, 1, 0);
    idle(4'd2, 0, 4'd2, 1, 0);
    idle(0, 0, 0, 0, 0);

    // Rejected load allocates nothing.
    step(0, L, 32'hA000, N, 0, 0, 4'd0, 0, L, 32'hA000, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 0);

    t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
